imem_arbiter: RTL and testbench

Arbitrates single-port access to the instruction memory between the fetch stage (reads) and the program loader (writes). The memory array has a 1-cycle registered read port. Fetch normally wins. A starvation counter guarantees the loader a slot within a bounded number of cycles, and a hold input lets the loader take the port exclusively for bulk programming. The block sits between the fetch stage, the loader and the word-addressed memory array.

---
 rtl/imem_arbiter_pkg.sv | 20 ++
 rtl/imem_starve_cnt.sv | 40 ++++
 rtl/imem_arbiter.sv | 123 ++++++++++++
 tb/tb_imem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction-memory arbiter: arbitration states and
// the byte-address to word-index rule used by the fetch and memory paths.
package imem_arbiter_pkg;

    // Arbitration modes: fetch priority, loader forced slot, loader exclusive hold
    typedef enum logic [1:0] {
        ARB_FETCH = 2'd0,
        ARB_FORCE = 2'd1,
        ARB_HOLD  = 2'd2
    } arb_state_e;

    // Byte offset bits dropped from a byte address to form a word index
    localparam int unsigned BYTE_OFS_W = 2;

    // Word index width for a memory of depth_words 32-bit words
    function automatic int unsigned idx_width(input int unsigned depth_words);
        return $clog2(depth_words);
    endfunction

endpackage

// File: rtl/imem_starve_cnt.sv
// Saturating count of consecutive denied loader cycles; flags when the next
// denial must be the last one before the loader is forced a slot.
module imem_starve_cnt #(
    parameter int unsigned MAX_LOAD_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_thresh
);

    localparam int unsigned CNT_W = $clog2(MAX_LOAD_WAIT + 1);
    localparam logic [CNT_W-1:0] THRESH = CNT_W'(MAX_LOAD_WAIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; count saturates at the threshold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != THRESH)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_thresh = (cnt_q == THRESH);

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction memory arbiter between fetch reads and loader writes.
// Fetch has priority; a starvation counter forces a loader slot and l_hold gives
// the loader exclusive access. Misaligned loader writes are acked but dropped.
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS   = 1024,
    parameter int unsigned MAX_LOAD_WAIT = 4,
    localparam int unsigned IDX_W        = idx_width(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_req,
    input  logic [31:0]      f_addr,
    output logic             f_gnt,
    output logic             f_rvalid,
    output logic [31:0]      f_rdata,
    input  logic             l_valid,
    input  logic [31:0]      l_addr,
    input  logic [31:0]      l_wdata,
    output logic             l_ready,
    input  logic             l_hold,
    output logic             m_en,
    output logic             m_we,
    output logic [IDX_W-1:0] m_addr,
    output logic [31:0]      m_wdata,
    input  logic [31:0]      m_rdata,
    output logic             err_misaligned
);

    arb_state_e state_q, state_d;
    logic       f_rvalid_q, f_rvalid_d;
    logic       err_q, err_d;
    logic       l_aligned;
    logic       ld_denied;
    logic       cnt_clr;
    logic       at_thresh;
    logic       unused_addr_bits;

    // Bits above the index alias modulo DEPTH_WORDS; fetch offset bits are ignored
    assign unused_addr_bits = ^{f_addr[31:IDX_W+BYTE_OFS_W], f_addr[BYTE_OFS_W-1:0],
                                l_addr[31:IDX_W+BYTE_OFS_W]};
    assign l_aligned = (l_addr[BYTE_OFS_W-1:0] == '0);

    // Grants from registered mode and live requests; nothing granted in reset
    always_comb begin
        f_gnt   = 1'b0;
        l_ready = 1'b0;
        if (!rst) begin
            case (state_q)
                ARB_FETCH: begin
                    if (f_req && !l_hold) begin
                        f_gnt = 1'b1;
                    end else begin
                        l_ready = l_valid;
                    end
                end
                ARB_FORCE, ARB_HOLD: l_ready = l_valid;
                default: ;
            endcase
        end
        ld_denied = l_valid && !l_ready;
        cnt_clr   = !l_valid || l_ready || (state_q == ARB_FORCE);
    end

    // Next mode: hold overrides everything, forced slot lasts one cycle
    always_comb begin
        state_d = state_q;
        if (l_hold) begin
            state_d = ARB_HOLD;
        end else begin
            case (state_q)
                ARB_FETCH: if (ld_denied && at_thresh) state_d = ARB_FORCE;
                ARB_FORCE: state_d = ARB_FETCH;
                ARB_HOLD:  state_d = ARB_FETCH;
                default:   state_d = ARB_FETCH;
            endcase
        end
    end

    // Memory port steering; a dropped misaligned write leaves the port idle
    always_comb begin
        m_we    = l_ready && l_aligned;
        m_en    = f_gnt || m_we;
        m_addr  = l_ready ? l_addr[IDX_W+BYTE_OFS_W-1:BYTE_OFS_W]
                          : f_addr[IDX_W+BYTE_OFS_W-1:BYTE_OFS_W];
        m_wdata = l_wdata;
    end

    // Read-valid tracks the grant; misalignment error is sticky
    always_comb begin
        f_rvalid_d = f_gnt;
        err_d      = err_q || (l_ready && !l_aligned);
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_FETCH;
            f_rvalid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            f_rvalid_q <= f_rvalid_d;
            err_q      <= err_d;
        end
    end

    assign f_rvalid       = f_rvalid_q;
    assign f_rdata        = m_rdata;
    assign err_misaligned = err_q;

    imem_starve_cnt #(
        .MAX_LOAD_WAIT(MAX_LOAD_WAIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (cnt_clr),
        .inc      (ld_denied),
        .at_thresh(at_thresh)
    );

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios plus a randomized run
// checked against a cycle-level reference model of the arbitration rules.
module tb_imem_arbiter;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned MLW   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_gnt, f_rvalid;
    logic [31:0] f_addr, f_rdata;
    logic        l_valid, l_ready, l_hold;
    logic [31:0] l_addr, l_wdata;
    logic        m_en, m_we;
    logic [9:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;
    logic        err_misaligned;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    imem_arbiter #(
        .DEPTH_WORDS  (DEPTH),
        .MAX_LOAD_WAIT(MLW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .f_req         (f_req),
        .f_addr        (f_addr),
        .f_gnt         (f_gnt),
        .f_rvalid      (f_rvalid),
        .f_rdata       (f_rdata),
        .l_valid       (l_valid),
        .l_addr        (l_addr),
        .l_wdata       (l_wdata),
        .l_ready       (l_ready),
        .l_hold        (l_hold),
        .m_en          (m_en),
        .m_we          (m_we),
        .m_addr        (m_addr),
        .m_wdata       (m_wdata),
        .m_rdata       (m_rdata),
        .err_misaligned(err_misaligned)
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    // Memory array with registered read port, reloaded on reset
    logic [31:0] mem [DEPTH];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_word(i);
            m_rdata <= '0;
        end else begin
            if (m_en && m_we) mem[m_addr] <= m_wdata;
            if (m_en && !m_we) m_rdata <= mem[m_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f_req = 0; f_addr = '0; l_valid = 0; l_addr = '0; l_wdata = '0; l_hold = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1; f_req = 1; l_valid = 1;
        tick(); tick();
        tests_run++; if (f_gnt !== 1'b0) begin tests_failed++; $display("FAIL rst_fgnt got %b exp 0", f_gnt); end
        tests_run++; if (l_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_lready got %b exp 0", l_ready); end
        tests_run++; if (f_rvalid !== 1'b0) begin tests_failed++; $display("FAIL rst_rvalid got %b exp 0", f_rvalid); end
        tests_run++; if (err_misaligned !== 1'b0) begin tests_failed++; $display("FAIL rst_err got %b exp 0", err_misaligned); end
        rst = 0; #1;
        // Fetch priority out of reset shows the arbiter starts in fetch mode
        tests_run++; if (f_gnt !== 1'b1 || l_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_state got f_gnt=%b l_ready=%b exp 1 0", f_gnt, l_ready); end
        tick();
        l_valid = 0;
        #1;
        tests_run++; if (f_gnt !== 1'b1) begin tests_failed++; $display("FAIL midread_gnt got %b exp 1", f_gnt); end
        rst = 1; #1;
        tests_run++; if (f_gnt !== 1'b0) begin tests_failed++; $display("FAIL midread_gnt_in_rst got %b exp 0", f_gnt); end
        tick();
        tests_run++; if (f_rvalid !== 1'b0) begin tests_failed++; $display("FAIL midread_rvalid got %b exp 0", f_rvalid); end
        rst = 0; idle_inputs(); #1;
        tick();
        tests_run++; if (f_rvalid !== 1'b0) begin tests_failed++; $display("FAIL post_rst_rvalid got %b exp 0", f_rvalid); end
    endtask

    task automatic test_fetch_stream();
        for (int i = 0; i < 3; i++) begin
            f_req = 1; f_addr = 32'(i * 4); #1;
            tests_run++; if (f_gnt !== 1'b1 || m_en !== 1'b1 || m_we !== 1'b0) begin tests_failed++; $display("FAIL fetch_gnt[%0d] got gnt=%b en=%b we=%b exp 1 1 0", i, f_gnt, m_en, m_we); end
            tests_run++; if (m_addr !== 10'(i)) begin tests_failed++; $display("FAIL fetch_maddr[%0d] got %0d exp %0d", i, m_addr, i); end
            tick();
            tests_run++; if (f_rvalid !== 1'b1 || f_rdata !== init_word(i)) begin tests_failed++; $display("FAIL fetch_data[%0d] got v=%b %h exp 1 %h", i, f_rvalid, f_rdata, init_word(i)); end
        end
        f_req = 0; #1;
        tick();
        tests_run++; if (f_rvalid !== 1'b0) begin tests_failed++; $display("FAIL fetch_stop got %b exp 0", f_rvalid); end
    endtask

    task automatic test_starvation();
        f_req = 1; f_addr = 32'h20; l_valid = 1; l_addr = 32'h10; l_wdata = 32'hDEADBEEF;
        for (int c = 1; c <= 5; c++) begin
            #1;
            tests_run++; if (l_ready !== (c == 5) || f_gnt !== (c != 5)) begin tests_failed++; $display("FAIL starve_c%0d got l_ready=%b f_gnt=%b exp %b %b", c, l_ready, f_gnt, c == 5, c != 5); end
            if (c == 5) begin
                tests_run++; if (m_we !== 1'b1 || m_addr !== 10'd4 || m_wdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL starve_write got we=%b addr=%0d data=%h exp 1 4 deadbeef", m_we, m_addr, m_wdata); end
            end
            tick();
        end
        l_valid = 0; f_addr = 32'h10; #1;
        tests_run++; if (f_gnt !== 1'b1) begin tests_failed++; $display("FAIL starve_resume got %b exp 1", f_gnt); end
        tick();
        tests_run++; if (f_rvalid !== 1'b1 || f_rdata !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL starve_readback got v=%b %h exp 1 deadbeef", f_rvalid, f_rdata); end
        idle_inputs();
    endtask

    task automatic test_hold();
        l_hold = 1; f_req = 1; f_addr = '0;
        for (int i = 0; i < 3; i++) begin
            l_valid = 1; l_addr = 32'(i * 4); l_wdata = 32'h1111_0000 + 32'(i); #1;
            tests_run++; if (f_gnt !== 1'b0 || l_ready !== 1'b1) begin tests_failed++; $display("FAIL hold_w%0d got f_gnt=%b l_ready=%b exp 0 1", i, f_gnt, l_ready); end
            tests_run++; if (m_we !== 1'b1 || m_addr !== 10'(i)) begin tests_failed++; $display("FAIL hold_m%0d got we=%b addr=%0d exp 1 %0d", i, m_we, m_addr, i); end
            tick();
        end
        l_valid = 0; #1;
        tests_run++; if (f_gnt !== 1'b0 || l_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_idle got f_gnt=%b l_ready=%b exp 0 0", f_gnt, l_ready); end
        tick();
        l_hold = 0; f_addr = 32'h4; #1;
        tests_run++; if (f_gnt !== 1'b0) begin tests_failed++; $display("FAIL hold_release_same got %b exp 0", f_gnt); end
        tick();
        tests_run++; if (f_gnt !== 1'b1) begin tests_failed++; $display("FAIL hold_release_next got %b exp 1", f_gnt); end
        tick();
        tests_run++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h1111_0001) begin tests_failed++; $display("FAIL hold_readback got v=%b %h exp 1 11110001", f_rvalid, f_rdata); end
        idle_inputs();
    endtask

    task automatic test_misaligned();
        tests_run++; if (err_misaligned !== 1'b0) begin tests_failed++; $display("FAIL mis_pre got %b exp 0", err_misaligned); end
        l_valid = 1; l_addr = 32'h6; l_wdata = 32'hBAD0BAD0; #1;
        tests_run++; if (l_ready !== 1'b1 || m_en !== 1'b0) begin tests_failed++; $display("FAIL mis_drop got l_ready=%b m_en=%b exp 1 0", l_ready, m_en); end
        tick();
        l_valid = 0; #1;
        tests_run++; if (err_misaligned !== 1'b1) begin tests_failed++; $display("FAIL mis_set got %b exp 1", err_misaligned); end
        for (int k = 0; k < 3; k++) begin
            f_req = 1; f_addr = 32'(k * 4);
            tick();
            tests_run++; if (err_misaligned !== 1'b1) begin tests_failed++; $display("FAIL mis_sticky[%0d] got %b exp 1", k, err_misaligned); end
        end
        idle_inputs();
        rst = 1; #1;
        tests_run++; if (err_misaligned !== 1'b0) begin tests_failed++; $display("FAIL mis_clear got %b exp 0", err_misaligned); end
        tick();
        rst = 0; #1;
    endtask

    task automatic test_wrap();
        l_valid = 1; l_addr = 32'h1004; l_wdata = 32'h5A5A1234; #1;
        tests_run++; if (l_ready !== 1'b1 || m_we !== 1'b1 || m_addr !== 10'd1) begin tests_failed++; $display("FAIL wrap_write got rdy=%b we=%b addr=%0d exp 1 1 1", l_ready, m_we, m_addr); end
        tick();
        l_valid = 0; f_req = 1; f_addr = 32'h4;
        tick();
        tests_run++; if (f_rvalid !== 1'b1 || f_rdata !== 32'h5A5A1234) begin tests_failed++; $display("FAIL wrap_readback got v=%b %h exp 1 5a5a1234", f_rvalid, f_rdata); end
        idle_inputs();
        tick();
    endtask

    // Reference model: fetch wins unless hold is on now or was on last cycle, or
    // the loader has just been denied MLW times in a row.
    logic [31:0] ref_mem [DEPTH];

    task automatic test_random();
        bit          hold_prev, force_slot, mdl_rvalid, mdl_err;
        bit          exp_fg, exp_lr, exp_we, exp_en, aligned, denied;
        int          streak, hold_run;
        logic [31:0] mdl_rdata;
        logic [9:0]  exp_idx;
        idle_inputs();
        rst = 1; tick(); rst = 0; #1;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        hold_prev = 0; force_slot = 0; mdl_rvalid = 0; mdl_err = 0; streak = 0; hold_run = 0;
        mdl_rdata = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (hold_run == 0 && $urandom_range(0, 19) == 0) hold_run = $urandom_range(1, 5);
            l_hold = (hold_run > 0);
            if (hold_run > 0) hold_run--;
            f_req   = ($urandom_range(0, 9) < 7);
            f_addr  = $urandom();
            l_valid = ($urandom_range(0, 1) == 1);
            l_addr  = $urandom();
            if ($urandom_range(0, 39) != 0) l_addr[1:0] = 2'b00;
            l_wdata = $urandom();
            #1;
            exp_fg  = f_req && !l_hold && !hold_prev && !force_slot;
            exp_lr  = l_valid && !exp_fg;
            aligned = (l_addr[1:0] == 2'b00);
            exp_we  = exp_lr && aligned;
            exp_en  = exp_fg || exp_we;
            exp_idx = exp_lr ? l_addr[11:2] : f_addr[11:2];
            tests_run++; if (f_gnt !== exp_fg || l_ready !== exp_lr) begin tests_failed++; $display("FAIL rnd_gnt c%0d got f_gnt=%b l_ready=%b exp %b %b", cyc, f_gnt, l_ready, exp_fg, exp_lr); end
            tests_run++; if (m_en !== exp_en || m_we !== exp_we) begin tests_failed++; $display("FAIL rnd_mctl c%0d got en=%b we=%b exp %b %b", cyc, m_en, m_we, exp_en, exp_we); end
            if (exp_en) begin
                tests_run++; if (m_addr !== exp_idx) begin tests_failed++; $display("FAIL rnd_maddr c%0d got %0d exp %0d", cyc, m_addr, exp_idx); end
            end
            tests_run++; if (f_rvalid !== mdl_rvalid) begin tests_failed++; $display("FAIL rnd_rvalid c%0d got %b exp %b", cyc, f_rvalid, mdl_rvalid); end
            if (mdl_rvalid) begin
                tests_run++; if (f_rdata !== mdl_rdata) begin tests_failed++; $display("FAIL rnd_rdata c%0d got %h exp %h", cyc, f_rdata, mdl_rdata); end
            end
            tests_run++; if (err_misaligned !== mdl_err) begin tests_failed++; $display("FAIL rnd_err c%0d got %b exp %b", cyc, err_misaligned, mdl_err); end
            // Advance the model across the clock edge
            denied     = l_valid && !exp_lr;
            streak     = denied ? streak + 1 : 0;
            force_slot = !l_hold && denied && (streak >= MLW);
            if (force_slot) streak = 0;
            hold_prev  = l_hold;
            mdl_rvalid = exp_fg;
            if (exp_fg) mdl_rdata = ref_mem[f_addr[11:2]];
            if (exp_we) ref_mem[l_addr[11:2]] = l_wdata;
            mdl_err    = mdl_err || (exp_lr && !aligned);
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_fetch_stream();
        test_starvation();
        test_hold();
        test_misaligned();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
